// File: rtl/note_input_encoder.sv
// Keyboard front end: synchronizes and debounces note keys and buttons, encodes a
// first-press mono note, tracks octave, and passes the ADSR selector through.
module note_input_encoder #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        iClock,
  input  logic        iResetn,
  input  logic [11:0] iKeys,
  input  logic        iOctUp,
  input  logic        iOctDn,
  input  logic        iAdsrUp,
  input  logic        iAdsrDn,
  input  logic [2:0]  iAdsrSel,
  output logic [3:0]  note,
  output logic        note_in,
  output logic        octave_plus_plus,
  output logic        octave_minus_minus,
  output logic        ADSR_plus_plus,
  output logic        ADSR_minus_minus,
  output logic [2:0]  ADSR_selector,
  output logic [2:0]  octave
);

  localparam int          NB       = 16;
  localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

  typedef enum logic {IDLE, HELD} state_t;

  logic [NB-1:0]       w_raw;
  logic [NB-1:0]       r_sync1;
  logic [NB-1:0]       r_sync2;
  logic [NB-1:0]       r_db;
  logic [NB-1:0][15:0] r_cnt;
  logic [2:0]          r_sel1;
  logic [2:0]          r_sel2;
  state_t              r_state;
  logic [11:0]         w_keys_db;
  logic                w_up_rise;
  logic                w_dn_rise;

  // Bits 0..11 are keys, 12..15 are OctUp, OctDn, AdsrUp, AdsrDn.
  assign w_raw     = {iAdsrDn, iAdsrUp, iOctDn, iOctUp, iKeys};
  assign w_keys_db = r_db[11:0];

  // Registered button levels double as the previous db value for edge detection.
  assign w_up_rise = r_db[12] & ~octave_plus_plus;
  assign w_dn_rise = r_db[13] & ~octave_minus_minus;

  function automatic logic [3:0] lowest_key(input logic [11:0] k);
    lowest_key = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (k[i]) lowest_key = 4'(i);
    end
  endfunction

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_cnt   <= '0;
      r_sel1  <= '0;
      r_sel2  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_sel1  <= iAdsrSel;
      r_sel2  <= r_sel1;
      for (int b = 0; b < NB; b++) begin
        if (r_sync2[b] == r_db[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CNT_LAST) begin
          r_db[b]  <= r_sync2[b];
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + 16'd1;
        end
      end
    end
  end

  // Mono note FSM: the first key pressed owns the note until every key is up.
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      r_state <= IDLE;
      note    <= 4'd0;
      note_in <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_keys_db) begin
            r_state <= HELD;
            note    <= lowest_key(w_keys_db);
            note_in <= 1'b1;
          end
        end
        HELD: begin
          if (!(|w_keys_db)) begin
            r_state <= IDLE;
            note_in <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          note_in <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      octave_plus_plus   <= 1'b0;
      octave_minus_minus <= 1'b0;
      ADSR_plus_plus     <= 1'b0;
      ADSR_minus_minus   <= 1'b0;
      ADSR_selector      <= 3'd0;
      octave             <= 3'd4;
    end else begin
      octave_plus_plus   <= r_db[12];
      octave_minus_minus <= r_db[13];
      ADSR_plus_plus     <= r_db[14];
      ADSR_minus_minus   <= r_db[15];
      ADSR_selector      <= r_sel2;
      if (w_up_rise && !w_dn_rise && octave != 3'd7) begin
        octave <= octave + 3'd1;
      end else if (w_dn_rise && !w_up_rise && octave != 3'd0) begin
        octave <= octave - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_note_input_encoder.sv
// Directed bench for note_input_encoder with a short debounce window (4 cycles).
module tb_note_input_encoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] keys;
  logic        oct_up, oct_dn, adsr_up, adsr_dn;
  logic [2:0]  adsr_sel;
  logic [3:0]  note;
  logic        note_in;
  logic        opp, omm, app, amm;
  logic [2:0]  sel_out;
  logic [2:0]  octave;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  note_input_encoder #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .iClock(clk), .iResetn(rstn), .iKeys(keys),
    .iOctUp(oct_up), .iOctDn(oct_dn), .iAdsrUp(adsr_up), .iAdsrDn(adsr_dn),
    .iAdsrSel(adsr_sel), .note(note), .note_in(note_in),
    .octave_plus_plus(opp), .octave_minus_minus(omm),
    .ADSR_plus_plus(app), .ADSR_minus_minus(amm),
    .ADSR_selector(sel_out), .octave(octave)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    tick(3);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; keys = '0; oct_up = 0; oct_dn = 0; adsr_up = 0; adsr_dn = 0; adsr_sel = 3'd0;
    tick(3);
    n_total++;
    if ({note, note_in, opp, omm, app, amm, sel_out, octave} !== {4'd0, 1'b0, 4'b0, 3'd0, 3'd4})
      $display("FAIL reset_outputs note=%0d note_in=%0b btn=%b%b%b%b sel=%0d oct=%0d want 0 0 0000 0 4",
               note, note_in, opp, omm, app, amm, sel_out, octave);
    else n_pass++;
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic test_adsr_sel();
    adsr_sel = 3'd5;
    tick(2);
    n_total++;
    if (sel_out !== 3'd0) $display("FAIL sel_early got %0d want 0", sel_out); else n_pass++;
    tick(1);
    n_total++;
    if (sel_out !== 3'd5) $display("FAIL sel_latency3 got %0d want 5", sel_out); else n_pass++;
  endtask

  task automatic test_note_press();
    keys = 12'h020;
    tick(6);
    n_total++;
    if (note_in !== 1'b0) $display("FAIL press_early note_in got %0b want 0", note_in); else n_pass++;
    tick(1);
    n_total++;
    if (note_in !== 1'b1 || note !== 4'd5)
      $display("FAIL press_at7 note_in=%0b note=%0d want 1 5", note_in, note);
    else n_pass++;
    keys = '0;
    tick(6);
    n_total++;
    if (note_in !== 1'b1) $display("FAIL release_early note_in got %0b want 1", note_in); else n_pass++;
    tick(1);
    n_total++;
    if (note_in !== 1'b0 || note !== 4'd5)
      $display("FAIL release_at7 note_in=%0b note=%0d want 0 5", note_in, note);
    else n_pass++;
  endtask

  task automatic test_short_pulse();
    logic seen = 1'b0;
    keys = 12'h008;
    tick(3);
    keys = '0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (note_in !== 1'b0) seen = 1'b1;
    end
    n_total++;
    if (seen || note !== 4'd5)
      $display("FAIL short_pulse note_in_seen=%0b note=%0d want 0 5", seen, note);
    else n_pass++;
  endtask

  task automatic test_two_keys();
    keys = 12'h204;
    tick(7);
    n_total++;
    if (note_in !== 1'b1 || note !== 4'd2)
      $display("FAIL two_keys_low note_in=%0b note=%0d want 1 2", note_in, note);
    else n_pass++;
    keys = 12'h200;
    tick(10);
    n_total++;
    if (note_in !== 1'b1 || note !== 4'd2)
      $display("FAIL mono_hold note_in=%0b note=%0d want 1 2", note_in, note);
    else n_pass++;
    keys = '0;
    tick(7);
    n_total++;
    if (note_in !== 1'b0 || note !== 4'd2)
      $display("FAIL mono_release note_in=%0b note=%0d want 0 2", note_in, note);
    else n_pass++;
  endtask

  task automatic test_octave_up();
    logic [2:0] exp_oct;
    apply_reset();
    tick(1);
    n_total++;
    if (octave !== 3'd4) $display("FAIL oct_start got %0d want 4", octave); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      exp_oct = (4 + i + 1 > 7) ? 3'd7 : 3'(4 + i + 1);
      oct_up = 1'b1;
      tick(6);
      n_total++;
      if (octave !== ((4 + i > 7) ? 3'd7 : 3'(4 + i)))
        $display("FAIL oct_up_early%0d got %0d want %0d", i, octave, (4 + i > 7) ? 7 : 4 + i);
      else n_pass++;
      tick(1);
      n_total++;
      if (octave !== exp_oct || opp !== 1'b1)
        $display("FAIL oct_up%0d octave=%0d opp=%0b want %0d 1", i, octave, opp, exp_oct);
      else n_pass++;
      oct_up = 1'b0;
      tick(8);
    end
  endtask

  task automatic test_octave_both(input logic [2:0] exp_oct);
    oct_up = 1'b1; oct_dn = 1'b1;
    tick(10);
    n_total++;
    if (octave !== exp_oct || opp !== 1'b1 || omm !== 1'b1)
      $display("FAIL oct_both octave=%0d opp=%0b omm=%0b want %0d 1 1", octave, opp, omm, exp_oct);
    else n_pass++;
    oct_up = 1'b0; oct_dn = 1'b0;
    tick(8);
  endtask

  task automatic test_octave_down_hold();
    oct_dn = 1'b1;
    tick(7);
    n_total++;
    if (octave !== 3'd6 || omm !== 1'b1)
      $display("FAIL dn_step octave=%0d omm=%0b want 6 1", octave, omm);
    else n_pass++;
    tick(13);
    n_total++;
    if (octave !== 3'd6 || omm !== 1'b1)
      $display("FAIL dn_no_repeat octave=%0d omm=%0b want 6 1", octave, omm);
    else n_pass++;
    oct_dn = 1'b0;
    tick(7);
    n_total++;
    if (omm !== 1'b0) $display("FAIL dn_release omm got %0b want 0", omm); else n_pass++;
  endtask

  task automatic test_octave_floor();
    for (int i = 0; i < 7; i++) begin
      oct_dn = 1'b1;
      tick(7);
      n_total++;
      if (octave !== ((5 - i < 0) ? 3'd0 : 3'(5 - i)))
        $display("FAIL oct_dn%0d got %0d want %0d", i, octave, (5 - i < 0) ? 0 : 5 - i);
      else n_pass++;
      oct_dn = 1'b0;
      tick(8);
    end
  endtask

  task automatic test_adsr_buttons();
    adsr_up = 1'b1;
    tick(6);
    n_total++;
    if (app !== 1'b0) $display("FAIL adsr_up_early got %0b want 0", app); else n_pass++;
    tick(1);
    n_total++;
    if (app !== 1'b1 || amm !== 1'b0)
      $display("FAIL adsr_up app=%0b amm=%0b want 1 0", app, amm);
    else n_pass++;
    adsr_up = 1'b0; adsr_dn = 1'b1;
    tick(7);
    n_total++;
    if (app !== 1'b0 || amm !== 1'b1)
      $display("FAIL adsr_dn app=%0b amm=%0b want 0 1", app, amm);
    else n_pass++;
    adsr_dn = 1'b0;
    tick(8);
  endtask

  task automatic test_reset_in_held();
    keys = 12'h080;
    tick(7);
    n_total++;
    if (note_in !== 1'b1 || note !== 4'd7)
      $display("FAIL held_pre note_in=%0b note=%0d want 1 7", note_in, note);
    else n_pass++;
    rstn = 1'b0;
    tick(1);
    n_total++;
    if ({note, note_in, opp, omm, app, amm, sel_out, octave} !== {4'd0, 1'b0, 4'b0, 3'd0, 3'd4})
      $display("FAIL reset_held note=%0d note_in=%0b btn=%b%b%b%b sel=%0d oct=%0d want 0 0 0000 0 4",
               note, note_in, opp, omm, app, amm, sel_out, octave);
    else n_pass++;
    rstn = 1'b1;
    tick(6);
    n_total++;
    if (note_in !== 1'b0) $display("FAIL redebounce_early note_in got %0b want 0", note_in); else n_pass++;
    tick(1);
    n_total++;
    if (note_in !== 1'b1 || note !== 4'd7)
      $display("FAIL redebounce note_in=%0b note=%0d want 1 7", note_in, note);
    else n_pass++;
    keys = '0;
    tick(8);
  endtask

  initial begin
    test_reset();
    test_adsr_sel();
    test_note_press();
    test_short_pulse();
    test_two_keys();
    test_octave_up();
    test_octave_both(3'd7);
    test_octave_down_hold();
    test_octave_both(3'd6);
    test_octave_floor();
    test_adsr_buttons();
    test_reset_in_held();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/note_input_encoder.md
NOTE_INPUT_ENCODER -- requirements
Module: note_input_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd50000, is the number of consecutive stable cycles required to accept an input change (1 ms at 50 MHz); legal range 2..65535.
REQ-002 iClock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 iResetn  input  1  reset, synchronous, active-low.
REQ-004 iKeys  input  12  raw asynchronous note keys, active-high, bit k = note code k (0=C .. 11=B).
REQ-005 iOctUp, iOctDn, iAdsrUp, iAdsrDn  input  1 each  raw asynchronous buttons, active-high.
REQ-006 iAdsrSel  input  3  raw asynchronous ADSR parameter selector switches.
REQ-007 note  output  4  latched note code for the display/synth stage.
REQ-008 note_in  output  1  high while the latched note is held.
REQ-009 octave_plus_plus, octave_minus_minus, ADSR_plus_plus, ADSR_minus_minus  output  1 each  debounced button levels.
REQ-010 ADSR_selector  output  3  synchronized selector value.
REQ-011 octave  output  3  current octave, 0..7.

Function
REQ-012 Every raw input bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each of the 16 key/button bits SHALL have an independent debouncer: a state bit db and a 16-bit counter cnt.
REQ-014 Debouncer: if sync == db, cnt <= 0; if sync != db and cnt == DEBOUNCE_CYCLES-1, db <= sync and cnt <= 0; otherwise cnt <= cnt+1.
REQ-015 A sync pulse shorter than DEBOUNCE_CYCLES cycles SHALL NOT change db; any return to db value mid-count restarts the count.
REQ-016 Latency: a raw change held stable SHALL appear on db exactly DEBOUNCE_CYCLES+2 cycles after the first edge that samples it, and on note/note_in/button outputs one cycle later (DEBOUNCE_CYCLES+3 total).
REQ-017 Note FSM states IDLE and HELD; note_in SHALL be 1 exactly in HELD.
REQ-018 IDLE -> HELD when any db key is set; note <= index of lowest set db key, same cycle as the transition.
REQ-019 In HELD, note SHALL NOT change while any db key is set, even if the original key is released and another remains pressed (first-press mono behaviour).
REQ-020 HELD -> IDLE when all 12 db keys are clear; note SHALL retain its last value in IDLE so the downstream stage can erase at the same position.
REQ-021 Simultaneous first press of several keys: the lowest index SHALL win.
REQ-022 Button outputs SHALL equal their db bits, registered (one cycle after db).
REQ-023 Rising edge of db(iOctUp) SHALL increment octave, saturating at 7; rising edge of db(iOctDn) SHALL decrement, saturating at 0.
REQ-024 Rising edges of both octave buttons in the same cycle SHALL leave octave unchanged.
REQ-025 A held octave button SHALL cause exactly one step; no auto-repeat.
REQ-026 ADSR_selector SHALL equal the synchronized iAdsrSel, registered once more (3-cycle latency, no debounce).

Reset
REQ-027 While iResetn is 0 at a clock edge: note=0, note_in=0, all four button outputs=0, ADSR_selector=0, octave=4, FSM=IDLE, all synchronizer flops, db bits and counters = 0.
REQ-028 Reset asserted mid-debounce or in HELD SHALL abort the count and return to IDLE with no note_in pulse on release of reset; a key still pressed SHALL be re-debounced from zero.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Press iKeys[5] and hold -> note_in rises and note=5 exactly 7 cycles after the first sampling edge; release -> note_in falls 7 cycles after, note stays 5.
REQ-030 iKeys[3] high for 3 cycles then low -> note_in never asserts, note unchanged.
REQ-031 Press iKeys[9] and iKeys[2] in the same cycle -> note=2; release key 2 while 9 held -> note stays 2, note_in stays 1 until key 9 is released.
REQ-032 Eight separate iOctUp presses from reset -> octave 4,5,6,7,7,7,7,7; then both buttons pressed in the same cycle -> octave stays 7.
REQ-033 Hold iOctDn 20 cycles -> octave decrements once; octave_minus_minus high for the debounced duration.
REQ-034 Assert iResetn=0 while in HELD with key still pressed -> all outputs at reset values next edge; after release of reset note_in reasserts 7 cycles later.
